// File: rtl/rect_plotter_if.sv
// rect_plotter_if
// Command and pixel-stream bundle between a rectangle-fill draw engine and its client.
//
// Signals:
//   cmd_valid / cmd_ready             command handshake
//   cmd_x, cmd_y                      rectangle origin (left column, top row)
//   cmd_w, cmd_h                      rectangle size in pixels (0 legal)
//   cmd_colour                        fill colour
//   cmd_outline                       border-only drawing (present only with RECT_PLOTTER_OUTLINE_EN)
//   x, y, colour, plot                pixel write port toward the VGA adapter
//   busy, done                        engine status
//
// Modports:
//   master  command issuer (game FSM); drives cmd_*, observes status and pixels
//   slave   draw engine; consumes cmd_*, drives cmd_ready, pixel port and status
interface rect_plotter_if #(
  parameter int COORD_W  = 8,
  parameter int COLOUR_W = 3
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [COORD_W-1:0]  cmd_x;
  logic [COORD_W-1:0]  cmd_y;
  logic [COORD_W-1:0]  cmd_w;
  logic [COORD_W-1:0]  cmd_h;
  logic [COLOUR_W-1:0] cmd_colour;
`ifdef RECT_PLOTTER_OUTLINE_EN
  logic                cmd_outline;
`endif
  logic [COORD_W-1:0]  x;
  logic [COORD_W-1:0]  y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                done;

`ifdef RECT_PLOTTER_OUTLINE_EN
  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour, cmd_outline,
    input  cmd_ready, x, y, colour, plot, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour, cmd_outline,
    output cmd_ready, x, y, colour, plot, busy, done
  );
`else
  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
    input  cmd_ready, x, y, colour, plot, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
    output cmd_ready, x, y, colour, plot, busy, done
  );
`endif
endinterface

// File: rtl/rect_plotter.sv
// rect_plotter
// Rectangle-fill draw engine: takes one rectangle command per handshake and
// streams one pixel per clock, in raster order, into the VGA adapter write port.
// Pixels falling outside SCREEN_W x SCREEN_H still take their cycle but do not plot.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-low reset
//   bus   rect_plotter_if.slave (command handshake, pixel port, busy/done)
//
// Optional feature macro: RECT_PLOTTER_OUTLINE_EN
//   Adds bus.cmd_outline; when latched high only border pixels are plotted,
//   interior pixels keep their cycle with plot low.
module rect_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COORD_W  = 8,
  parameter int COLOUR_W = 3
) (
  input logic           clk,
  input logic           rst,
  rect_plotter_if.slave bus
);

  localparam logic [0:0]         S_IDLE = 1'b0;
  localparam logic [0:0]         S_DRAW = 1'b1;
  localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
  localparam logic [COORD_W:0]   LIM_X  = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0]   LIM_Y  = (COORD_W+1)'(SCREEN_H);

  // Sums are one bit wider than the coordinates so an origin near the edge
  // plus an offset can never wrap back onto the screen.
  function automatic logic in_bounds(input logic [COORD_W:0] sx,
                                     input logic [COORD_W:0] sy);
    return (sx < LIM_X) && (sy < LIM_Y);
  endfunction

`ifdef RECT_PLOTTER_OUTLINE_EN
  function automatic logic on_border(input logic [COORD_W-1:0] col,
                                     input logic [COORD_W-1:0] row,
                                     input logic [COORD_W-1:0] w,
                                     input logic [COORD_W-1:0] h);
    return (col == '0) || (col == w - ONE) || (row == '0) || (row == h - ONE);
  endfunction
`endif

  logic [0:0]          r_state;
  logic [COORD_W-1:0]  r_ox;
  logic [COORD_W-1:0]  r_oy;
  logic [COORD_W-1:0]  r_w;
  logic [COORD_W-1:0]  r_h;
  logic [COORD_W-1:0]  r_col;
  logic [COORD_W-1:0]  r_row;
  logic [COORD_W-1:0]  r_x;
  logic [COORD_W-1:0]  r_y;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_plot;
  logic                r_busy;
  logic                r_done;
`ifdef RECT_PLOTTER_OUTLINE_EN
  logic                r_outline;
`endif

  logic               w_accept;
  logic               w_zero;
  logic               w_last_col;
  logic               w_last_row;
  logic [COORD_W-1:0] w_nxt_col;
  logic [COORD_W-1:0] w_nxt_row;
  logic [COORD_W:0]   w_sum_x;
  logic [COORD_W:0]   w_sum_y;
  logic               w_plot_nxt;
  logic               w_plot_first;

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.x         = r_x;
  assign bus.y         = r_y;
  assign bus.colour    = r_colour;
  assign bus.plot      = r_plot;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  assign w_accept   = bus.cmd_valid && (r_state == S_IDLE);
  assign w_zero     = (bus.cmd_w == '0) || (bus.cmd_h == '0);
  assign w_last_col = (r_col == r_w - ONE);
  assign w_last_row = (r_row == r_h - ONE);
  assign w_nxt_col  = w_last_col ? '0 : r_col + ONE;
  assign w_nxt_row  = w_last_col ? r_row + ONE : r_row;
  assign w_sum_x    = {1'b0, r_ox} + {1'b0, w_nxt_col};
  assign w_sum_y    = {1'b0, r_oy} + {1'b0, w_nxt_row};

  // Pixel (0,0) is always on the border, so outline mode never masks it.
  assign w_plot_first = in_bounds({1'b0, bus.cmd_x}, {1'b0, bus.cmd_y});
`ifdef RECT_PLOTTER_OUTLINE_EN
  assign w_plot_nxt = in_bounds(w_sum_x, w_sum_y) &&
                      (!r_outline || on_border(w_nxt_col, w_nxt_row, r_w, r_h));
`else
  assign w_plot_nxt = in_bounds(w_sum_x, w_sum_y);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_col    <= '0;
      r_row    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_plot <= 1'b0;
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          r_ox  <= bus.cmd_x;
          r_oy  <= bus.cmd_y;
          r_w   <= bus.cmd_w;
          r_h   <= bus.cmd_h;
          r_col <= '0;
          r_row <= '0;
`ifdef RECT_PLOTTER_OUTLINE_EN
          r_outline <= bus.cmd_outline;
`endif
          if (w_zero) begin
            r_done <= 1'b1;
          end else begin
            // First pixel goes out on the accepting edge to save a cycle.
            r_state  <= S_DRAW;
            r_busy   <= 1'b1;
            r_x      <= bus.cmd_x;
            r_y      <= bus.cmd_y;
            r_colour <= bus.cmd_colour;
            r_plot   <= w_plot_first;
          end
        end
      end else begin
        if (w_last_col && w_last_row) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_col  <= w_nxt_col;
          r_row  <= w_nxt_row;
          r_x    <= w_sum_x[COORD_W-1:0];
          r_y    <= w_sum_y[COORD_W-1:0];
          r_plot <= w_plot_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// tb_rect_plotter
// Bench for rect_plotter: directed scenarios plus randomized rectangles.
// Expected pixel/done events come from a reference model that enumerates the
// rectangle's pixels directly; a separate monitor pops and compares them
// whenever the engine plots or signals done.
module tb_rect_plotter;
  localparam int CW = 8;
  localparam int KW = 3;
  localparam int SW = 160;
  localparam int SH = 120;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rect_plotter_if #(.COORD_W(CW), .COLOUR_W(KW)) bus();

  rect_plotter #(
    .SCREEN_W(SW), .SCREEN_H(SH), .COORD_W(CW), .COLOUR_W(KW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_done;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [KW-1:0] c;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: every pixel of the rectangle in raster order, kept only if on screen
  // (and on the border when outlined), followed by one done event.
  task automatic push_model(input int ox, input int oy, input int w, input int h,
                            input logic [KW-1:0] c, input bit outl);
    ev_t e;
    int  sx;
    int  sy;
    bit  border;
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        sx     = ox + k;
        sy     = oy + r;
        border = (k == 0) || (k == w - 1) || (r == 0) || (r == h - 1);
        if (sx < SW && sy < SH && (!outl || border)) begin
          e.is_done = 1'b0;
          e.x = CW'(sx);
          e.y = CW'(sy);
          e.c = c;
          exp_q.push_back(e);
        end
      end
    end
    e.is_done = 1'b1;
    e.x = '0;
    e.y = '0;
    e.c = '0;
    exp_q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (bus.plot === 1'b1 || bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        if (bus.done) check("unexpected_done", 1, 0);
        else          check("unexpected_plot", 1, 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (bus.done) begin
          check("done_event", longint'(e.is_done), 1);
        end else begin
          check("pixel_kind", longint'(e.is_done), 0);
          check("pixel_x_y_colour", longint'({bus.x, bus.y, bus.colour}),
                longint'({e.x, e.y, e.c}));
        end
      end
    end
  end

  task automatic drive_cmd(input int ox, input int oy, input int w, input int h,
                           input logic [KW-1:0] c, input bit outl);
    bus.cmd_x      = CW'(ox);
    bus.cmd_y      = CW'(oy);
    bus.cmd_w      = CW'(w);
    bus.cmd_h      = CW'(h);
    bus.cmd_colour = c;
`ifdef RECT_PLOTTER_OUTLINE_EN
    bus.cmd_outline = outl;
`else
    if (outl) $display("outline requested in a build without outline support");
`endif
  endtask

  // Presents a command and returns just after the accepting edge.
  task automatic issue(input int ox, input int oy, input int w, input int h,
                       input logic [KW-1:0] c, input bit outl, output bit ok);
    int waitc;
    waitc = 0;
    ok    = 1'b0;
    drive_cmd(ox, oy, w, h, c, outl);
    bus.cmd_valid = 1'b1;
    while (!ok && waitc < 64) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        push_model(ox, oy, w, h, c, outl);
        ok = 1'b1;
      end
      waitc++;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  // Issues a command and checks cycle-level timing; pulse_at >= 0 injects a
  // one-cycle foreign command at that cycle of the draw.
  task automatic run_cmd(input int ox, input int oy, input int w, input int h,
                         input logic [KW-1:0] c, input bit outl, input int pulse_at);
    bit ok;
    bit seen;
    int busy_n;
    int cyc;
    int done_at;
    busy_n  = 0;
    cyc     = 0;
    seen    = 1'b0;
    done_at = -1;
    issue(ox, oy, w, h, c, outl, ok);
    if (!ok) return;
    while (!seen && cyc < w * h + 8) begin
      @(negedge clk);
      if (cyc == pulse_at) begin
        drive_cmd(50, 50, 2, 2, 3'b010, 1'b0);
        bus.cmd_valid = 1'b1;
      end else if (cyc == pulse_at + 1) begin
        bus.cmd_valid = 1'b0;
      end
      if (cyc == 0) check("first_cycle_busy", longint'(bus.busy), longint'(w * h > 0));
      if (bus.busy) busy_n++;
      if (bus.done) begin
        seen    = 1'b1;
        done_at = cyc;
      end
      cyc++;
    end
    bus.cmd_valid = 1'b0;
    check("done_seen", longint'(seen), 1);
    check("done_latency", done_at, w * h);
    check("busy_cycles", busy_n, w * h);
    @(negedge clk);
    check("done_single_pulse", longint'(bus.done), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    bit got;
    int cyc;
    int rw;
    int rh;
    bit ro;

    // Reset with a command pending
    drive_cmd(20, 20, 4, 4, 3'b101, 1'b0);
    bus.cmd_valid = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_plot", longint'(bus.plot), 0);
    check("reset_done", longint'(bus.done), 0);
    check("reset_busy", longint'(bus.busy), 0);
    check("reset_xy", longint'({bus.x, bus.y}), 0);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ready_after_reset", longint'(bus.cmd_ready), 1);
    @(posedge clk);
    #1;

    // Paddle fill
    run_cmd(10, 52, 1, 16, 3'b111, 1'b0, -1);

    // Raster order, then a second command held valid through completion
    issue(5, 5, 3, 2, 3'b100, 1'b0, ok);
    if (ok) begin
      drive_cmd(0, 0, 1, 1, 3'b001, 1'b0);
      bus.cmd_valid = 1'b1;
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 40) begin
        @(negedge clk);
        if (bus.done) begin
          check("b2b_ready_in_done_cycle", longint'(bus.cmd_ready), 1);
          check("b2b_first_done_latency", cyc, 6);
          push_model(0, 0, 1, 1, 3'b001, 1'b0);
          got = 1'b1;
        end
        cyc++;
      end
      check("b2b_done_seen", longint'(got), 1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      check("b2b_second_first_pixel", longint'({bus.plot, bus.busy, bus.x, bus.y}),
            longint'({1'b1, 1'b1, 8'd0, 8'd0}));
      @(negedge clk);
      check("b2b_second_done", longint'(bus.done), 1);
      @(posedge clk);
      #1;
    end

    // Clipping at the bottom-right corner
    run_cmd(158, 119, 4, 2, 3'b010, 1'b0, -1);

    // Zero-size commands
    run_cmd(30, 30, 0, 5, 3'b011, 1'b0, -1);
    run_cmd(30, 30, 5, 0, 3'b011, 1'b0, -1);

    // Foreign command pulsed while busy
    run_cmd(10, 52, 1, 16, 3'b110, 1'b0, 3);

    // Reset in the middle of a draw
    issue(10, 52, 1, 16, 3'b111, 1'b0, ok);
    if (ok) begin
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      rst = 1'b1;
      @(negedge clk);
      check("midreset_plot", longint'(bus.plot), 0);
      check("midreset_busy", longint'(bus.busy), 0);
      check("midreset_done", longint'(bus.done), 0);
      repeat (3) @(negedge clk);
      check("midreset_no_late_done", longint'(bus.done), 0);
      check("midreset_ready", longint'(bus.cmd_ready), 1);
      @(posedge clk);
      #1;
    end

`ifdef RECT_PLOTTER_OUTLINE_EN
    run_cmd(0, 0, 4, 3, 3'b101, 1'b1, -1);
`endif

    // Randomized rectangles, biased toward the screen edges
    for (int i = 0; i < 30; i++) begin
      rw = $urandom_range(0, 6);
      rh = $urandom_range(0, 6);
      if ($urandom_range(0, 4) == 0) rw = $urandom_range(7, 20);
`ifdef RECT_PLOTTER_OUTLINE_EN
      ro = 1'($urandom_range(0, 1));
`else
      ro = 1'b0;
`endif
      run_cmd($urandom_range(0, 165), $urandom_range(0, 125), rw, rh,
              KW'($urandom_range(0, 7)), ro, -1);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

endmodule
